mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
MEM-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB register.
- Converts lw/lh/lhu/lb/lbu/sw/sh/sb requests into a variable-latency req/ack data-memory transaction.
- Stalls the pipeline until the transaction completes.
- Delivers the aligned, extended load word on RD for MEM/WB to capture.
- Flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for dmem_ack before bus error.
CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
MemRead  in  1  load in EX/MEM
MemWrite  in  1  store in EX/MEM
Size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
Unsigned  in  1  zero-extend load (lbu/lhu)
ALUout  in  32  effective byte address
WD  in  32  store data (rt value)
dmem_req  out  1  memory request
dmem_we  out  1  write enable, valid with dmem_req
dmem_addr  out  32  word address, {ALUout[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  one-cycle completion pulse
dmem_rdata  in  32  read data, valid with dmem_ack
RD  out  32  registered load result to MEM/WB
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB loads a bubble
misalign  out  1  one-cycle exception pulse
bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst=0, async): state IDLE; RD=0; counter=0; dmem_req, dmem_we, misalign and bus_err = 0; dmem_be=0.
- op = MemRead|MemWrite; if both are set, treat as a read.
- Byte order: little-endian. Lane = ALUout[1:0].
- Alignment: a half is misaligned if ALUout[0]=1; a word is misaligned if ALUout[1:0]!=0.
- FSM:
  - IDLE:
    - No op: stall=0; stay in IDLE.
    - Op and misaligned: stall=1 (combinational); next state DONE; misalign=1 in DONE; RD<=0; no memory request.
    - Op and aligned: stall=1 (combinational); next state BUSY; counter<=0.
  - BUSY:
    - dmem_req=1 and stall=1; dmem_addr, dmem_we, dmem_be and dmem_wdata are driven from the current inputs, which stay stable because of the stall.
    - On dmem_ack: for reads, RD<=extracted data; for writes, RD is unchanged. Next state DONE.
    - No ack and counter==TIMEOUT-1: RD<=0; bus_err=1 in DONE; next state DONE.
    - Otherwise: counter++.
  - DONE:
    - stall=0 and dmem_req=0. At the closing edge, MEM/WB captures RD and EX/MEM advances.
    - Next state IDLE unconditionally, so the completed op is never reissued.
- Latency: minimum 3 cycles per memory op (IDLE, BUSY with same-cycle ack, DONE). Non-memory instructions: 0 extra cycles.
- Byte enables:
  - byte: 4'b0001<<lane
  - half: 4'b0011<<lane
  - word: 4'b1111
- Store data replication:
  - byte: {4{WD[7:0]}}
  - half: {2{WD[15:0]}}
  - word: WD
- Load extraction:
  - byte: rdata[8*lane+:8], sign- or zero-extended per Unsigned
  - half: rdata[8*lane+:16] (lane 0 or 2), sign- or zero-extended per Unsigned
  - word: rdata
- An ack arriving in IDLE or DONE is ignored.
- An ack in the same cycle the counter reaches the limit: the ack wins and bus_err=0.
- rst asserted mid-BUSY: dmem_req drops immediately and the transaction is abandoned. The memory must tolerate an abandoned request.

Decomposition:
- Shared package: Size encodings (SZ_WORD/SZ_HALF/SZ_BYTE) and FSM state encoding (IDLE/BUSY/DONE), reused by the hazard unit and the MEM/WB writeback mux.
- One natural sub-module, mem_lane_align: purely combinational store lane/BE generation and load extract/extend. It is unit-testable in isolation.

Test Plan:
- Aligned lw, ALUout=0x0000_0104, ack after 2 BUSY cycles, rdata=0xDEAD_BEEF -> dmem_addr=0x104, be=1111, stall high 3 cycles, RD=0xDEADBEEF in DONE.
- lb/lbu at ALUout=0x103, rdata=0x80AA_BBCC -> be=1000; RD=0xFFFF_FF80 (signed) and 0x0000_0080 (Unsigned).
- sh at ALUout=0x202, WD=0x1234_5678 -> dmem_we=1, be=1100, wdata=0x5678_5678; RD unchanged.
- lw at ALUout=0x102 -> no dmem_req, misalign pulses for 1 cycle, RD=0, stall for 1 cycle.
- No ack with TIMEOUT=16 -> dmem_req high exactly 16 cycles, then bus_err pulse and RD=0. Ack on the 16th cycle -> no bus_err.
- rst low during BUSY -> dmem_req and stall low immediately, state IDLE. Op still present after release -> a fresh request starts.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
// Also used by the hazard unit and the MEM/WB writeback mux.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // The reserved size behaves as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_HALF: return lane[0];
      SZ_BYTE: return 1'b0;
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and the memory.
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational little-endian lane logic: store byte enables and replication,
// load extraction with sign/zero extension.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(rdata >> {lane, 3'b000});
    // Halves only reach memory at lane 0 or 2, so lane[1] picks the half.
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    be        = 4'b1111;
    wdata     = wd;
    load_data = rdata;

    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata     = {4{wd[7:0]}};
        load_data = is_unsigned ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be        = 4'b0011 << lane;
        wdata     = {2{wd[15:0]}};
        load_data = is_unsigned ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        be        = 4'b1111;
        wdata     = wd;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: issues req/ack transactions, stalls the
// pipeline until completion, and reports misaligned accesses and timeouts.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [1:0]               Size,
  input  logic                     Unsigned,
  input  logic [31:0]              ALUout,
  input  logic [31:0]              WD,
  mem_access_ctrl_if.master        dmem,
  output logic [31:0]              RD,
  output logic                     stall,
  output logic                     misalign,
  output logic                     bus_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;

  size_e       size;
  logic [1:0]  lane;
  logic        op;
  logic        bad_align;
  logic        at_limit;
  logic        busy;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  assign size      = size_e'(Size);
  assign lane      = ALUout[1:0];
  assign op        = MemRead | MemWrite;
  assign bad_align = is_misaligned(size, lane);
  assign at_limit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign busy      = (state_q == BUSY);

  mem_lane_align u_lane_align (
    .size        (size),
    .is_unsigned (Unsigned),
    .lane        (lane),
    .wd          (WD),
    .rdata       (dmem.dmem_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op) begin
          stall = 1'b1;
          cnt_d = '0;
          if (bad_align) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            rd_d       = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // Ack has priority over the timeout in the same cycle.
        if (dmem.dmem_ack) begin
          if (MemRead) rd_d = load_data;
          state_d = DONE;
        end else if (at_limit) begin
          rd_d      = '0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reset abandons any transaction, so the pipeline must not be held.
    if (!rst) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem.dmem_req   = busy;
  assign dmem.dmem_we    = busy & MemWrite & ~MemRead;
  assign dmem.dmem_addr  = {ALUout[31:2], 2'b00};
  assign dmem.dmem_be    = busy ? lane_be : '0;
  assign dmem.dmem_wdata = lane_wdata;

  assign RD       = rd_q;
  assign misalign = misalign_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Unsigned;
  logic [1:0]  Size;
  logic [31:0] ALUout, WD;
  logic [31:0] RD;
  logic        stall, misalign, bus_err;

  always #5 clk = ~clk;

  mem_access_ctrl_if dmem_if ();

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Size     (Size),
    .Unsigned (Unsigned),
    .ALUout   (ALUout),
    .WD       (WD),
    .dmem     (dmem_if),
    .RD       (RD),
    .stall    (stall),
    .misalign (misalign),
    .bus_err  (bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int stall_n, req_n;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    MemRead  = rd;
    MemWrite = wr;
    Size     = sz;
    Unsigned = uns;
    ALUout   = addr;
    WD       = wd;
  endtask

  // Leaves DONE with the op withdrawn, as EX/MEM advancing would.
  task automatic finish_op();
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  // Runs from IDLE (op already applied) until DONE; acks on BUSY cycle ack_at (0 = never).
  task automatic run_txn(input int ack_at, input logic [31:0] rdata);
    stall_n   = 0;
    req_n     = 0;
    obs_be    = 'x;
    obs_we    = 1'bx;
    obs_addr  = 'x;
    obs_wdata = 'x;
    #1;
    for (int c = 0; c < 40 && stall; c++) begin
      if (dmem_if.dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          obs_be    = dmem_if.dmem_be;
          obs_we    = dmem_if.dmem_we;
          obs_addr  = dmem_if.dmem_addr;
          obs_wdata = dmem_if.dmem_wdata;
        end
        if (req_n == ack_at) begin
          dmem_if.dmem_ack   = 1'b1;
          dmem_if.dmem_rdata = rdata;
        end
      end
      stall_n++;
      @(posedge clk); #1;
      dmem_if.dmem_ack = 1'b0;
    end
    check_eq("txn_bound_stall", 32'(stall), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = 32'h0;
    #3 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_rd",       RD, 32'h0);
    check_eq("rst_req",      32'(dmem_if.dmem_req), 32'h0);
    check_eq("rst_we",       32'(dmem_if.dmem_we), 32'h0);
    check_eq("rst_be",       32'(dmem_if.dmem_be), 32'h0);
    check_eq("rst_misalign", 32'(misalign), 32'h0);
    check_eq("rst_bus_err",  32'(bus_err), 32'h0);
    check_eq("rst_stall",    32'(stall), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Ack while idle must be ignored.
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_if.dmem_ack = 1'b0;
    #1;
    check_eq("idle_ack_rd",    RD, 32'h0);
    check_eq("idle_ack_stall", 32'(stall), 32'h0);
    check_eq("idle_ack_req",   32'(dmem_if.dmem_req), 32'h0);

    // lw 0x104, ack on second BUSY cycle.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    run_txn(2, 32'hDEAD_BEEF);
    check_eq("lw_req_cycles",   32'(req_n), 32'd2);
    check_eq("lw_stall_cycles", 32'(stall_n), 32'd3);
    check_eq("lw_addr",         obs_addr, 32'h0000_0104);
    check_eq("lw_be",           32'(obs_be), 32'hF);
    check_eq("lw_we",           32'(obs_we), 32'h0);
    check_eq("lw_rd",           RD, 32'hDEAD_BEEF);
    check_eq("lw_done_req",     32'(dmem_if.dmem_req), 32'h0);
    check_eq("lw_done_flags",   {30'h0, misalign, bus_err}, 32'h0);
    finish_op();
    check_eq("lw_idle_stall",   32'(stall), 32'h0);

    // sh 0x202: upper half lanes, replicated data, RD untouched.
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_5678);
    run_txn(1, 32'hFFFF_FFFF);
    check_eq("sh_we",    32'(obs_we), 32'h1);
    check_eq("sh_be",    32'(obs_be), 32'hC);
    check_eq("sh_wdata", obs_wdata, 32'h5678_5678);
    check_eq("sh_addr",  obs_addr, 32'h0000_0200);
    check_eq("sh_rd",    RD, 32'hDEAD_BEEF);
    check_eq("sh_stall_cycles", 32'(stall_n), 32'd2);
    finish_op();

    // lb / lbu at lane 3.
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0);
    run_txn(1, 32'h80AA_BBCC);
    check_eq("lb_be", 32'(obs_be), 32'h8);
    check_eq("lb_rd", RD, 32'hFFFF_FF80);
    finish_op();
    set_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0);
    run_txn(1, 32'h80AA_BBCC);
    check_eq("lbu_rd", RD, 32'h0000_0080);
    finish_op();

    // sb at lane 1: replication and single-lane enable.
    set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'hA5A5_A53C);
    run_txn(1, 32'h0);
    check_eq("sb_be",    32'(obs_be), 32'h2);
    check_eq("sb_wdata", obs_wdata, 32'h3C3C_3C3C);
    finish_op();

    // lh at lane 2, sign-extended.
    set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
    run_txn(1, 32'h80AA_BBCC);
    check_eq("lh_be", 32'(obs_be), 32'hC);
    check_eq("lh_rd", RD, 32'hFFFF_80AA);
    finish_op();

    // Misaligned lw: no request, RD cleared, one-cycle pulse.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
    run_txn(1, 32'h0);
    check_eq("mis_req_cycles",   32'(req_n), 32'd0);
    check_eq("mis_stall_cycles", 32'(stall_n), 32'd1);
    check_eq("mis_flag",         32'(misalign), 32'h1);
    check_eq("mis_rd",           RD, 32'h0);
    finish_op();
    check_eq("mis_pulse_end",    32'(misalign), 32'h0);

    // Reserved size behaves as a word.
    set_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0108, 32'h0);
    run_txn(1, 32'h0123_4567);
    check_eq("rsvd_be", 32'(obs_be), 32'hF);
    check_eq("rsvd_rd", RD, 32'h0123_4567);
    finish_op();

    // No ack: 16 request cycles, then bus error and RD cleared.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    run_txn(0, 32'h0);
    check_eq("to_req_cycles", 32'(req_n), 32'd16);
    check_eq("to_bus_err",    32'(bus_err), 32'h1);
    check_eq("to_rd",         RD, 32'h0);
    finish_op();
    check_eq("to_pulse_end",  32'(bus_err), 32'h0);

    // Ack on the 16th cycle wins over the timeout; a later ack in DONE is ignored.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    run_txn(16, 32'h5A5A_1234);
    check_eq("ack16_req_cycles", 32'(req_n), 32'd16);
    check_eq("ack16_bus_err",    32'(bus_err), 32'h0);
    check_eq("ack16_rd",         RD, 32'h5A5A_1234);
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'h0BAD_0BAD;
    finish_op();
    dmem_if.dmem_ack = 1'b0;
    #1;
    check_eq("done_ack_rd",  RD, 32'h5A5A_1234);
    check_eq("done_ack_req", 32'(dmem_if.dmem_req), 32'h0);

    // Reset mid-BUSY abandons the request; op still present restarts it.
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    #1;
    @(posedge clk); #1;
    check_eq("rstb_busy_req", 32'(dmem_if.dmem_req), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rstb_req",   32'(dmem_if.dmem_req), 32'h0);
    check_eq("rstb_stall", 32'(stall), 32'h0);
    #2 rst = 1'b1;
    #1;
    check_eq("rstb_idle_stall", 32'(stall), 32'h1);
    check_eq("rstb_idle_req",   32'(dmem_if.dmem_req), 32'h0);
    run_txn(1, 32'hCAFE_F00D);
    check_eq("rstb_req_cycles", 32'(req_n), 32'd1);
    check_eq("rstb_rd",         RD, 32'hCAFE_F00D);
    finish_op();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
